// File: rtl/mac_exec_sequencer_if.sv
// rtl/mac_exec_sequencer_if.sv - control/status bundle between the exec sequencer, FIFOs and MAC8
interface mac_exec_sequencer_if #(
  parameter int N = 8
);
  logic         go;
  logic         load_done;
  logic [N-1:0] a_empty;
  logic         b_empty;
  logic [N-1:0] a_rden;
  logic         b_rden;
  logic         mac_en;
  logic         mac_clr;
  logic         busy;
  logic         done;
  logic         error;

  modport master (
    output go, load_done, a_empty, b_empty,
    input  a_rden, b_rden, mac_en, mac_clr, busy, done, error
  );

  modport slave (
    input  go, load_done, a_empty, b_empty,
    output a_rden, b_rden, mac_en, mac_clr, busy, done, error
  );
endinterface

// File: rtl/mac_exec_sequencer.sv
// rtl/mac_exec_sequencer.sv - drains A/B FIFOs into MAC8: clear, DEPTH accumulates, drain, done
module mac_exec_sequencer #(
  parameter int N            = 8,
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_MAX    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_exec_sequencer_if.slave  bus
);
  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOAD, S_PRELOAD, S_MAC, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [DW-1:0] drain_cnt, drain_nx;
  logic [SW-1:0] stall_cnt, stall_nx;
  logic          any_empty;
  logic          last_k;
  logic          stall;
  logic          rd;
  logic          mac_en_d;
  logic          mac_clr_d;
  logic          busy_d;
  logic          done_d;
  logic          error_d;

  assign any_empty = (|bus.a_empty) | bus.b_empty;
  assign last_k    = (k == KW'(DEPTH - 1));
  // The final MAC cycle consumes data already on o_data, so it can never stall.
  assign stall     = ((state == S_PRELOAD) || ((state == S_MAC) && !last_k)) && any_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      drain_cnt <= drain_nx;
      stall_cnt <= stall_nx;
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    drain_nx = '0;
    stall_nx = stall ? stall_cnt + 1'b1 : '0;
    case (state)
      S_IDLE:      if (bus.go) state_nx = bus.load_done ? S_PRELOAD : S_WAIT_LOAD;
      S_WAIT_LOAD: if (bus.load_done) state_nx = S_PRELOAD;
      S_PRELOAD: begin
        if (!any_empty) begin
          state_nx = S_MAC;
          k_nx     = '0;
        end
      end
      S_MAC: begin
        if (last_k)          state_nx = S_DRAIN;
        else if (!any_empty) k_nx     = k + 1'b1;
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nx = S_DONE;
        else                                    drain_nx = drain_cnt + 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
    if (stall && (stall_cnt == SW'(STALL_MAX - 1))) state_nx = S_ERR;
  end

  always_comb begin
    rd        = 1'b0;
    mac_en_d  = 1'b0;
    mac_clr_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state)
      S_IDLE:  busy_d = 1'b0;
      S_PRELOAD: begin
        mac_clr_d = 1'b1;
        rd        = !any_empty;
      end
      S_MAC: begin
        if (last_k) begin
          mac_en_d = 1'b1;
        end else if (!any_empty) begin
          mac_en_d = 1'b1;
          rd       = 1'b1;
        end
      end
      S_DONE:  done_d = 1'b1;
      S_ERR: begin
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.a_rden  = {N{rd}};
  assign bus.b_rden  = rd;
  assign bus.mac_en  = mac_en_d;
  assign bus.mac_clr = mac_clr_d;
  assign bus.busy    = busy_d;
  assign bus.done    = done_d;
  assign bus.error   = error_d;
endmodule
